// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of the 8x8 register file
// between the ALU writeback (A) and the load/immediate unit (B).
module regfile_wr_arbiter #(
    parameter logic PRI_INIT = 1'b0,
    parameter logic DROP_R0  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       req_a,
    input  logic [2:0] addr_a,
    input  logic [7:0] data_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [2:0] addr_b,
    input  logic [7:0] data_b,
    output logic       gnt_b,
    output logic       we,
    output logic [2:0] wa,
    output logic [7:0] wd,
    output logic [7:0] pend,
    output logic       last_src
);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    logic       pri;
    logic       xfer_a;
    logic       xfer_b;
    logic       xfer;
    logic       contention;
    src_e       win_src;
    logic [2:0] win_addr;
    logic [7:0] win_data;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n && !hold) begin
            gnt_a = req_a && (!req_b || !pri);
            gnt_b = req_b && (!req_a ||  pri);
        end
    end

    assign xfer_a     = req_a & gnt_a;
    assign xfer_b     = req_b & gnt_b;
    assign xfer       = xfer_a | xfer_b;
    assign contention = req_a & req_b;

    always_comb begin
        win_src  = SRC_A;
        win_addr = addr_a;
        win_data = data_a;
        if (xfer_b) begin
            win_src  = SRC_B;
            win_addr = addr_b;
            win_data = data_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri      <= PRI_INIT;
            we       <= 1'b0;
            wa       <= 3'd0;
            wd       <= 8'd0;
            last_src <= 1'b0;
        end else begin
            if (xfer) begin
                wa       <= win_addr;
                wd       <= win_data;
                last_src <= win_src;
                we       <= !(DROP_R0 && (win_addr == 3'd0));
            end else begin
                we <= 1'b0;
            end
            // Pointer only moves when both contended; single-requester grants leave it alone.
            if (contention && xfer) begin
                pri <= xfer_a;
            end
        end
    end

    always_comb begin
        pend = 8'd0;
        if (we) begin
            pend[wa] = 1'b1;
        end
    end

endmodule
